mealy_seq_det1101: RTL and testbench



---
 rtl/mealy_seq_det1101.sv | 68 ++++++
 tb/tb_mealy_seq_det1101.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mealy_seq_det1101.sv
// -----------------------------------------------------------------------------
// mealy_seq_det1101
//
// Serial pattern detector for the bit sequence 1-1-0-1. One bit is consumed
// per clock. The detect flag is a Mealy output: it is decoded from the current
// state and the bit currently presented, so it rises in the same cycle the
// final '1' arrives, before the edge that consumes it.
//
// Parameters
//   OVERLAP      1: the trailing '1' of a match seeds the next match
//                0: the search restarts from scratch after each match
//
// Ports
//   clk          in   1  clock, state updates on the rising edge
//   rst_n        in   1  synchronous reset, ACTIVE-HIGH despite the name
//   in_bit       in   1  serial data bit, sampled at the rising edge
//   pattern_det  out  1  high while state is S110 and in_bit is 1
//
// State table
//   state | meaning
//   S0    | nothing matched
//   S1    | saw 1
//   S11   | saw 11 (a run of 1s keeps this prefix)
//   S110  | saw 110, next 1 completes the pattern
// -----------------------------------------------------------------------------
module mealy_seq_det1101 #(
  parameter int OVERLAP = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_bit,
  output logic pattern_det
);

  typedef enum logic [1:0] {
    S0   = 2'b00,
    S1   = 2'b01,
    S11  = 2'b10,
    S110 = 2'b11
  } state_t;

  // Where the search resumes after a completed match.
  localparam state_t S_AFTER_MATCH = (OVERLAP != 0) ? S1 : S0;

  state_t r_state;
  logic   w_match;

  assign w_match = (r_state == S110) && in_bit;

  // The port name is fixed for integration; reset is asserted when rst_n is 1.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state <= S0;
    end else begin
      case (r_state)
        S0:      r_state <= in_bit ? S1  : S0;
        S1:      r_state <= in_bit ? S11 : S0;
        S11:     r_state <= in_bit ? S11 : S110;
        S110:    r_state <= in_bit ? S_AFTER_MATCH : S0;
        default: r_state <= S0;
      endcase
    end
  end

  // Gated by reset so a stale S110 cannot flag while the block is held.
  assign pattern_det = w_match && !rst_n;

endmodule

// File: tb/tb_mealy_seq_det1101.sv
module tb_mealy_seq_det1101;

  logic clk;
  logic rst_n;
  logic in_bit;
  logic det_ov;
  logic det_no;

  int n_vec;
  int n_err;

  mealy_seq_det1101 #(.OVERLAP(1)) dut_ov (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_bit      (in_bit),
    .pattern_det (det_ov)
  );

  mealy_seq_det1101 #(.OVERLAP(0)) dut_no (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_bit      (in_bit),
    .pattern_det (det_no)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a bit just after the falling edge and let the output settle.
  task automatic drive(input logic b);
    @(negedge clk);
    in_bit = b;
    #1;
  endtask

  // Reset for n rising edges, then release at a falling edge with in_bit=0.
  task automatic apply_reset(input int n);
    @(negedge clk);
    rst_n  = 1'b1;
    in_bit = 1'b0;
    repeat (n) @(negedge clk);
    rst_n  = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n  = 1'b1;
    in_bit = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      n_vec++;
      if (det_ov !== 1'b0) begin
        n_err++;
        $display("FAIL reset_hold[%0d] ov: got %b want 0", i, det_ov);
      end
      n_vec++;
      if (det_no !== 1'b0) begin
        n_err++;
        $display("FAIL reset_hold[%0d] no: got %b want 0", i, det_no);
      end
    end
    rst_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0);
      n_vec++;
      if (det_ov !== 1'b0) begin
        n_err++;
        $display("FAIL reset_idle[%0d] ov: got %b want 0", i, det_ov);
      end
      n_vec++;
      if (det_no !== 1'b0) begin
        n_err++;
        $display("FAIL reset_idle[%0d] no: got %b want 0", i, det_no);
      end
    end
  endtask

  task automatic test_basic();
    logic [3:0] seq;
    logic [3:0] exp;
    seq = 4'b1101;
    exp = 4'b0001;
    apply_reset(2);
    for (int i = 3; i >= 0; i--) begin
      drive(seq[i]);
      n_vec++;
      if (det_ov !== exp[i]) begin
        n_err++;
        $display("FAIL basic_bit%0d ov: got %b want %b", 4 - i, det_ov, exp[i]);
      end
      n_vec++;
      if (det_no !== exp[i]) begin
        n_err++;
        $display("FAIL basic_bit%0d no: got %b want %b", 4 - i, det_no, exp[i]);
      end
    end
  endtask

  task automatic test_overlap();
    logic [6:0] seq;
    logic [6:0] exp_ov;
    logic [6:0] exp_no;
    seq    = 7'b1101101;
    exp_ov = 7'b0001001;
    exp_no = 7'b0001000;
    apply_reset(2);
    for (int i = 6; i >= 0; i--) begin
      drive(seq[i]);
      n_vec++;
      if (det_ov !== exp_ov[i]) begin
        n_err++;
        $display("FAIL overlap_bit%0d ov: got %b want %b", 7 - i, det_ov, exp_ov[i]);
      end
      n_vec++;
      if (det_no !== exp_no[i]) begin
        n_err++;
        $display("FAIL overlap_bit%0d no: got %b want %b", 7 - i, det_no, exp_no[i]);
      end
    end
  endtask

  task automatic test_runs();
    logic [10:0] seq;
    logic [10:0] exp;
    // 1,1,1,1,0,1 followed by 1,1,0,0,1
    seq = 11'b111101_11001;
    exp = 11'b000001_00000;
    apply_reset(2);
    for (int i = 10; i >= 0; i--) begin
      drive(seq[i]);
      n_vec++;
      if (det_ov !== exp[i]) begin
        n_err++;
        $display("FAIL runs_bit%0d ov: got %b want %b", 11 - i, det_ov, exp[i]);
      end
      n_vec++;
      if (det_no !== exp[i]) begin
        n_err++;
        $display("FAIL runs_bit%0d no: got %b want %b", 11 - i, det_no, exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] seq;
    seq = 3'b110;
    apply_reset(2);
    for (int i = 2; i >= 0; i--) begin
      drive(seq[i]);
      n_vec++;
      if (det_ov !== 1'b0) begin
        n_err++;
        $display("FAIL mid_prefix%0d ov: got %b want 0", 3 - i, det_ov);
      end
    end
    // State is now S110; a 1 under reset must not flag.
    @(negedge clk);
    rst_n  = 1'b1;
    in_bit = 1'b1;
    #1;
    n_vec++;
    if (det_ov !== 1'b0) begin
      n_err++;
      $display("FAIL mid_in_reset ov: got %b want 0", det_ov);
    end
    n_vec++;
    if (det_no !== 1'b0) begin
      n_err++;
      $display("FAIL mid_in_reset no: got %b want 0", det_no);
    end
    @(negedge clk);
    rst_n  = 1'b0;
    in_bit = 1'b1;
    #1;
    n_vec++;
    if (det_ov !== 1'b0) begin
      n_err++;
      $display("FAIL mid_after_reset ov: got %b want 0", det_ov);
    end
    n_vec++;
    if (det_no !== 1'b0) begin
      n_err++;
      $display("FAIL mid_after_reset no: got %b want 0", det_no);
    end
  endtask

  task automatic test_random();
    logic [2:0] h_ov;
    logic [2:0] h_no;
    logic       b;
    logic       e_ov;
    logic       e_no;
    h_ov = 3'b000;
    h_no = 3'b000;
    apply_reset(2);
    for (int i = 0; i < 200; i++) begin
      b = ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0;
      drive(b);
      e_ov = ({h_ov, b} == 4'b1101);
      e_no = ({h_no, b} == 4'b1101);
      n_vec++;
      if (det_ov !== e_ov) begin
        n_err++;
        $display("FAIL random[%0d] ov: got %b want %b", i, det_ov, e_ov);
      end
      n_vec++;
      if (det_no !== e_no) begin
        n_err++;
        $display("FAIL random[%0d] no: got %b want %b", i, det_no, e_no);
      end
      h_ov = {h_ov[1:0], b};
      h_no = e_no ? 3'b000 : {h_no[1:0], b};
    end
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    rst_n  = 1'b1;
    in_bit = 1'b0;
    test_reset();
    test_basic();
    test_overlap();
    test_runs();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
